// File: rtl/rf_writeback_buffer_if.sv
// Enqueue-side handshake bundle for rf_writeback_buffer: one pending register write per transfer.
interface rf_writeback_buffer_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] wsel;
  logic [DW-1:0] wdat;

  modport master (output valid, output wsel, output wdat, input ready);
  modport slave  (input valid, input wsel, input wdat, output ready);
endinterface

// File: rtl/rf_writeback_buffer.sv
// Writeback FIFO in front of register_file with optional newest-match read bypass.
// Define RF_WB_BYPASS_EN to enable the bypass; otherwise reads pass straight through.
module rf_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  rf_writeback_buffer_if.slave   enq,
  input  logic                   drain_en,
  output logic                   rf_WEN,
  output logic [AW-1:0]          rf_wsel,
  output logic [DW-1:0]          rf_wdat,
  input  logic [AW-1:0]          rsel1,
  input  logic [AW-1:0]          rsel2,
  input  logic [DW-1:0]          rf_rdat1,
  input  logic [DW-1:0]          rf_rdat2,
  output logic [DW-1:0]          rdat1,
  output logic [DW-1:0]          rdat2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] wsel_mem [DEPTH];
  logic [DW-1:0] wdat_mem [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW-1:0] head_next, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  assign enq.ready = !full & !RST;
  // Writes to r0 complete the handshake but never occupy an entry.
  assign push      = enq.valid & enq.ready & (enq.wsel != '0);
  assign rf_WEN    = drain_en & !empty & !RST;
  assign pop       = rf_WEN;
  assign rf_wsel   = wsel_mem[head_reg];
  assign rf_wdat   = wdat_mem[head_reg];

  always_comb begin
    head_next  = pop  ? head_reg + 1'b1 : head_reg;
    tail_next  = push ? tail_reg + 1'b1 : tail_reg;
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      wsel_mem[tail_reg] <= enq.wsel;
      wdat_mem[tail_reg] <= enq.wdat;
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic [DEPTH-1:0] hit1, hit2;
  logic [DW-1:0]    age_dat [DEPTH];

  // Slot gi is the gi-th oldest live entry; the head is included since it is
  // only captured by register_file at the end of this cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] idx;
    logic          live;
    assign idx         = head_reg + PW'(gi);
    assign live        = (count_reg > CW'(gi));
    assign hit1[gi]    = live && (rsel1 != '0) && (wsel_mem[idx] == rsel1);
    assign hit2[gi]    = live && (rsel2 != '0) && (wsel_mem[idx] == rsel2);
    assign age_dat[gi] = wdat_mem[idx];
  end

  always_comb begin
    rdat1 = rf_rdat1;
    rdat2 = rf_rdat2;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit1[i]) rdat1 = age_dat[i];
      if (hit2[i]) rdat2 = age_dat[i];
    end
  end
`else
  logic unused_rsel;
  assign unused_rsel = ^{rsel1, rsel2};
  assign rdat1       = rf_rdat1;
  assign rdat2       = rf_rdat2;
`endif
endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Scoreboard bench for rf_writeback_buffer: drained writes are checked against issue order.
module tb_rf_writeback_buffer;
  logic        CLK = 1'b0;
  logic        RST;
  logic        drain_en;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rf_rdat1, rf_rdat2;
  logic [31:0] rdat1, rdat2;
  logic [2:0]  count;
  logic        empty, full;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb [$];

  rf_writeback_buffer_if #(.AW(5), .DW(32)) ifc ();

  rf_writeback_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .enq      (ifc),
    .drain_en (drain_en),
    .rf_WEN   (rf_WEN),
    .rf_wsel  (rf_wsel),
    .rf_wdat  (rf_wdat),
    .rsel1    (rsel1),
    .rsel2    (rsel2),
    .rf_rdat1 (rf_rdat1),
    .rf_rdat2 (rf_rdat2),
    .rdat1    (rdat1),
    .rdat2    (rdat2),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  // Monitor: every drain must match the oldest outstanding expected write.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("wen_in_reset", 64'(rf_WEN), 64'd0);
      end else if (rf_WEN) begin
        if (sb.size() == 0) begin
          chk("unexpected_drain", 64'({rf_wsel, rf_wdat}), 64'd0);
        end else begin
          chk("drain", 64'({rf_wsel, rf_wdat}), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Called at posedge+1, returns at posedge+1 after the handshake edge.
  task automatic enq(input logic [4:0] s, input logic [31:0] d);
    int n;
    n = 0;
    ifc.valid = 1'b1;
    ifc.wsel  = s;
    ifc.wdat  = d;
    @(negedge CLK);
    while (!ifc.ready && n < 20) begin
      n++;
      @(negedge CLK);
    end
    if (!ifc.ready) begin
      chk("enq_timeout", 64'(ifc.ready), 64'd1);
    end else if (s != 5'd0) begin
      sb.push_back({s, d});
    end
    @(posedge CLK);
    #1;
    ifc.valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge CLK);
    while (!empty && n < 30) begin
      n++;
      @(negedge CLK);
    end
    chk("drained_empty", 64'(empty), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; drain_en = 1'b0;
    ifc.valid = 1'b0; ifc.wsel = '0; ifc.wdat = '0;
    rsel1 = '0; rsel2 = '0; rf_rdat1 = '0; rf_rdat2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1: reset with two writes queued, drain requested during reset
    enq(5'd1, 32'h1);
    enq(5'd2, 32'h2);
    chk("pre_reset_count", 64'(count), 64'd2);
    RST = 1'b1; drain_en = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("rst_ready", 64'(ifc.ready), 64'd0);
    chk("rst_wen", 64'(rf_WEN), 64'd0);
    @(negedge CLK);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0; drain_en = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 64'(ifc.ready), 64'd1);
    chk("post_rst_full", 64'(full), 64'd0);
    chk("post_rst_empty", 64'(empty), 64'd1);
    chk("post_rst_count", 64'(count), 64'd0);
    @(posedge CLK);
    #1;

    // 2: fill to DEPTH, hold a fifth request, then drain in order
    for (int i = 1; i <= 4; i++) enq(5'(i), 32'(i * 'h11));
    @(negedge CLK);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(ifc.ready), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head", 64'({rf_wsel, rf_wdat}), 64'({5'd1, 32'h11}));
    @(posedge CLK);
    #1;
    ifc.valid = 1'b1; ifc.wsel = 5'd5; ifc.wdat = 32'h55;
    repeat (2) begin
      @(negedge CLK);
      chk("held_count", 64'(count), 64'd4);
      @(posedge CLK);
      #1;
    end
    drain_en = 1'b1;
    enq(5'd5, 32'h55);
    wait_empty();

    // 3: r0 write is accepted and discarded
    enq(5'd0, 32'hDEAD);
    @(negedge CLK);
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_wen", 64'(rf_WEN), 64'd0);
    @(posedge CLK);
    #1;

    // 4: steady enqueue+drain at occupancy 2, pointers wrap
    drain_en = 1'b0;
    enq(5'd1, 32'hA1);
    enq(5'd2, 32'hA2);
    drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      enq(5'(3 + i), 32'(32'hB0 + i));
      chk("simul_count", 64'(count), 64'd2);
    end
    wait_empty();

    // 5: bypass picks the newest of duplicate entries
    drain_en = 1'b0;
    enq(5'd5, 32'hA);
    enq(5'd5, 32'hB);
    rsel1 = 5'd5; rf_rdat1 = 32'h0;
    rsel2 = 5'd6; rf_rdat2 = 32'h6666;
    @(negedge CLK);
`ifdef RF_WB_BYPASS_EN
    chk("byp_rdat1", 64'(rdat1), 64'hB);
`else
    chk("byp_rdat1", 64'(rdat1), 64'h0);
`endif
    chk("byp_rdat2_miss", 64'(rdat2), 64'h6666);
    @(posedge CLK);
    #1;
    rsel2 = 5'd0;
    @(negedge CLK);
    chk("byp_rsel0", 64'(rdat2), 64'h6666);
    @(posedge CLK);
    #1;
    drain_en = 1'b1;
    wait_empty();

    // 6: entry being drained still bypasses in its drain cycle
    drain_en = 1'b0;
    enq(5'd7, 32'h77);
    rsel1 = 5'd7; rf_rdat1 = 32'h0; drain_en = 1'b1;
    @(negedge CLK);
    chk("edge_wen", 64'(rf_WEN), 64'd1);
`ifdef RF_WB_BYPASS_EN
    chk("edge_rdat1", 64'(rdat1), 64'h77);
`else
    chk("edge_rdat1", 64'(rdat1), 64'h0);
`endif
    @(posedge CLK);
    #1;
    rf_rdat1 = 32'h77;
    @(negedge CLK);
    chk("after_edge_rdat1", 64'(rdat1), 64'h77);
    chk("after_edge_empty", 64'(empty), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
